// File: rtl/cube_calc_if.sv
// Request/result bundle for cube_calc: operand and start in, cube and status out.
// The state field exposes the controller state for observation.
interface cube_calc_if #(
  parameter int WIDTH = 8
);
  // start is a request sampled only while busy_o is low (IDLE). A rising clk
  // edge with start=1 in IDLE accepts it and captures x_in. done_o is a
  // one-cycle completion strobe qualifying y_out. There is no backpressure.
  logic                 start;
  logic [WIDTH-1:0]     x_in;
  logic [3*WIDTH-1:0]   y_out;
  logic                 busy_o;
  logic                 done_o;
  logic [1:0]           state;

  modport master (
    output start, x_in,
    input  y_out, busy_o, done_o, state
  );

  modport slave (
    input  start, x_in,
    output y_out, busy_o, done_o, state
  );
endinterface

// File: rtl/cube_calc.sv
// Sequential cuber y = x^3 using one shift-add multiplier pass for x*x, then sq*x.
// Optional CUBE_EARLY_EXIT_EN: operands 0 and 1 complete on the accepting edge.
module cube_calc #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  cube_calc_if.slave bus
);
  localparam int RW = 3 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   x_q, x_n;
  logic [RW-1:0]      acc_q, acc_n;
  logic [2*WIDTH-1:0] sq_q, sq_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [RW-1:0]      y_q, y_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  logic [RW-1:0]      mcand;
  logic [RW-1:0]      addend;
  logic [RW-1:0]      sum;
  logic               early;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      sq_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      acc_q   <= acc_n;
      sq_q    <= sq_n;
      cnt_q   <= cnt_n;
      y_q     <= y_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    acc_n   = acc_q;
    sq_n    = sq_q;
    cnt_n   = cnt_q;
    y_n     = y_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    // The single adder: multiplicand is x in the first pass, sq in the second.
    mcand  = (state_q == MUL2) ? {{WIDTH{1'b0}}, sq_q} : {{(2*WIDTH){1'b0}}, x_q};
    addend = x_q[cnt_q] ? (mcand << cnt_q) : '0;
    sum    = acc_q + addend;

`ifdef CUBE_EARLY_EXIT_EN
    early = (bus.x_in <= WIDTH'(1));
`else
    early = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (early) begin
            y_n    = RW'(bus.x_in);
            done_n = 1'b1;
          end else begin
            x_n     = bus.x_in;
            acc_n   = '0;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = MUL1;
          end
        end
      end
      MUL1: begin
        acc_n = sum;
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sq_n    = sum[2*WIDTH-1:0];
          acc_n   = '0;
          cnt_n   = '0;
          state_n = MUL2;
        end
      end
      MUL2: begin
        acc_n = sum;
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          y_n     = sum;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.y_out  = y_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_cube_calc.sv
// Directed bench for cube_calc: vector table, full operand sweep, and
// hand-written sequences for ignored start, back-to-back and mid-job reset.
module tb_cube_calc;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cube_calc_if #(.WIDTH(W)) bus ();
  cube_calc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [3*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   x;
    logic [3*W-1:0] y;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat_for(input logic [W-1:0] x);
`ifdef CUBE_EARLY_EXIT_EN
    if (x <= 1) return 0;
`endif
    return 16;
  endfunction

  // Called at a negedge; start is seen by the following posedge.
  task automatic drive_start(input logic [W-1:0] x, input logic [3*W-1:0] exp_y);
    bus.start = 1'b1;
    bus.x_in  = x;
    exp_q.push_back(exp_y);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in  = W'($urandom_range(0, 255));
  endtask

  // Returns at the negedge where done_o is high; lat counts busy negedges seen.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy_o) lat++;
      @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: no done_o within 40 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check({name, " y"}, 32'(bus.y_out), 32'(exp_q.pop_front()));
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd0,   24'd0};
    vecs[1] = '{8'd1,   24'd1};
    vecs[2] = '{8'd2,   24'd8};
    vecs[3] = '{8'd3,   24'd27};
    vecs[4] = '{8'd7,   24'd343};
    vecs[5] = '{8'd10,  24'd1000};
    vecs[6] = '{8'd16,  24'd4096};
    vecs[7] = '{8'd100, 24'd1000000};
    vecs[8] = '{8'd128, 24'd2097152};
    vecs[9] = '{8'd255, 24'd16581375};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    repeat (2) @(negedge clk);
    check("reset y", 32'(bus.y_out), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset done", 32'(bus.done_o), 32'd0);
    check("reset state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // x=3 single job, then done must drop and y must hold
    drive_start(8'd3, 24'd27);
    check("x3 state mul1", 32'(bus.state), 32'd1);
    wait_done("x3", 16);
    @(negedge clk);
    check("x3 done pulse", 32'(bus.done_o), 32'd0);
    check("x3 y hold", 32'(bus.y_out), 32'd27);

    for (int i = 0; i < 10; i++) begin
      drive_start(vecs[i].x, vecs[i].y);
      wait_done($sformatf("vec x=%0d", vecs[i].x), lat_for(vecs[i].x));
      @(negedge clk);
    end

    // Full sweep, each start issued on the done cycle of the previous job
    for (int x = 0; x < 256; x++) begin
      drive_start(W'(x), 24'(x * x * x));
      wait_done($sformatf("sweep x=%0d", x), lat_for(W'(x)));
    end
    @(negedge clk);

    // start with x=9 while busy on x=5 is ignored
    drive_start(8'd5, 24'd125);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", 13);
    @(negedge clk);
    check("ignore no requeue busy", 32'(bus.busy_o), 32'd0);
    check("ignore no requeue done", 32'(bus.done_o), 32'd0);

    // back-to-back
    drive_start(8'd2, 24'd8);
    wait_done("b2b x=2", 16);
    drive_start(8'd4, 24'd64);
    wait_done("b2b x=4", 16);
    @(negedge clk);

    // async reset at cycle 7 of x=200
    bus.start = 1'b1;
    bus.x_in  = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-reset busy", 32'(bus.busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst y", 32'(bus.y_out), 32'd0);
    check("async rst busy", 32'(bus.busy_o), 32'd0);
    check("async rst done", 32'(bus.done_o), 32'd0);
    check("async rst state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset y", 32'(bus.y_out), 32'd0);
    drive_start(8'd6, 24'd216);
    wait_done("after reset x=6", 16);
    @(negedge clk);

`ifdef CUBE_EARLY_EXIT_EN
    drive_start(8'd1, 24'd1);
    check("early busy", 32'(bus.busy_o), 32'd0);
    wait_done("early x=1", 0);
    @(negedge clk);
    check("early done pulse", 32'(bus.done_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
